ram64_block_mover: RTL and testbench
====================================

// Module: ram64_block_mover
// PURPOSE
//  Bus initiator for one RAM64 word-memory port: drives address/in/load and samples out.
//  Copies a block of words from src to dst within the same 64-word memory.
//  Overlapping ranges are handled like memmove.
//  Sits beside the CPU as a simple DMA engine; the top-level mux grants it the RAM port while busy=1.
// PARAMETERS
//  WIDTH   16  data word width; must match RAM word width
//  ADDR_W   6  address width; memory depth = 2**ADDR_W = 64
// PORTS
//  clk          in   1        single clock; all state changes on posedge
//  rst_n        in   1        asynchronous, active-low reset
//  start        in   1        request copy; sampled only while idle
//  src          in   ADDR_W   first source word address
//  dst          in   ADDR_W   first destination word address
//  len          in   ADDR_W+1 word count, 0..64; values >64 clamp to 64
//  busy         out  1        high from the cycle after start accept until done
//  done         out  1        one-cycle pulse when the copy completes
//  mem_address  out  ADDR_W   to RAM address
//  mem_in       out  WIDTH    to RAM in
//  mem_load     out  1        to RAM load; write happens at the posedge while high
//  mem_out      in   WIDTH    from RAM out; combinational read of mem_address
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy=0, done=0, mem_load=0, mem_address=0, mem_in=0.
//   Data register and counters are cleared.
//  States: IDLE, READ, WRITE, FINISH.
//  IDLE: outputs as at reset, except done. start=1 latches src, dst and clamped len.
//   len!=0 -> READ; len==0 -> FINISH (done pulses with no memory access).
//  Direction is decided at accept time:
//   - Descending if diff = (dst-src) mod 64 satisfies 1 <= diff < len.
//   - Otherwise ascending.
//   - Descending start pointers: src+len-1 and dst+len-1 (mod 64).
//  READ (1 cycle): mem_address = read pointer, mem_load=0; mem_out captured into the data
//   register at the posedge -> WRITE.
//  WRITE (1 cycle): mem_address = write pointer, mem_in = data register, mem_load=1.
//   At the posedge: both pointers step +/-1 mod 64 (wrap 63<->0) and remaining count decrements.
//   Next state is FINISH if remaining was 1, otherwise READ.
//  FINISH (1 cycle): done=1, busy=0, mem_load=0 -> IDLE. done is high only in FINISH.
//  busy=1 in READ and WRITE only. A copy of N words occupies exactly 2N busy cycles.
//   done asserts 2N+1 cycles after the start-accept edge.
//  start while not IDLE is ignored; no queueing. start in FINISH is also ignored.
//  src==dst: copy still runs (diff=0 -> ascending) and rewrites identical data.
//  Reset mid-operation: abort immediately; mem_load drops asynchronously; a partial copy
//   stays in RAM; no done pulse.
//  mem_load is a registered-state decode; no glitch on mem_load outside WRITE.
// STRUCTURE
//  Package ram_dma_pkg:
//   - WIDTH and ADDR_W defaults
//   - typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} dma_state_t
//   - typedef logic [ADDR_W-1:0] word_addr_t
//  Sub-module dma_addr_step: modular up/down pointer with load and step enable.
//   Instantiated twice (src and dst).
//  Top level holds the FSM, remaining counter, data register and direction flag.
//  Bench pairs it with the RAM64 model (address/in/load/out wired directly).
// TESTING
//  1 Preload RAM[i]=i+100. start src=0 dst=32 len=4 -> RAM[32..35]=100..103.
//    done at cycle 9 after accept; busy high 8 cycles.
//  2 Overlap forward: src=10 dst=12 len=4, RAM[10..15]=A..F -> RAM[12..15]=A,B,C,D.
//    Trace shows descending addresses 13,15,12,14,...
//  3 Wrap: src=62 dst=5 len=4 -> RAM[5..8] = old RAM[62],RAM[63],RAM[0],RAM[1].
//  4 len=0 -> no mem_load pulse, busy stays 0, done one cycle after accept.
//    len=100 -> treated as 64, 128 busy cycles.
//  5 start pulsed mid-copy with different args -> ignored; first copy result unchanged.
//  6 Deassert rst_n during the 2nd WRITE of len=4 -> mem_load=0 same cycle, no done.
//    Only 1 word written; next start works normally.

Source files
------------

// File: rtl/ram_dma_pkg.sv
// Shared types and default sizes for the RAM64 block mover.
package ram_dma_pkg;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 6;

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} dma_state_t;
  typedef logic [DEF_ADDR_W-1:0] word_addr_t;
endpackage

// File: rtl/ram64_block_mover_if.sv
// Word-memory port between the block mover (master) and the RAM (slave).
interface ram64_block_mover_if
  import ram_dma_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] mem_address;
  logic [WIDTH-1:0]  mem_in;
  logic              mem_load;
  logic [WIDTH-1:0]  mem_out;

  modport master (output mem_address, mem_in, mem_load, input mem_out);
  modport slave  (input mem_address, mem_in, mem_load, output mem_out);
endinterface

// File: rtl/dma_addr_step.sv
// Wrapping word pointer: parallel load, or step by one up or down.
module dma_addr_step #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (load) ptr <= load_val;
    else if (step) ptr <= down ? ptr - ADDR_W'(1) : ptr + ADDR_W'(1);
  end
endmodule

// File: rtl/ram64_block_mover.sv
// memmove-style block copy inside one word memory: one READ then one WRITE cycle per word.
module ram64_block_mover
  import ram_dma_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src,
  input  logic [ADDR_W-1:0]   dst,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  ram64_block_mover_if.master mem
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  dma_state_t        state, state_nxt;
  logic [ADDR_W:0]   len_c, remaining;
  logic [ADDR_W-1:0] diff, len_m1, rd_ptr, wr_ptr;
  logic              desc_now, dir_down, accept, step;
  logic [WIDTH-1:0]  data_q;

  assign len_c    = (len > DEPTH) ? DEPTH : len;
  assign diff     = dst - src;
  assign len_m1   = ADDR_W'(len_c - (ADDR_W+1)'(1));
  // Destination lands ahead of the source inside the block: copy from the top down.
  assign desc_now = (diff != '0) && ({1'b0, diff} < len_c);
  assign accept   = (state == IDLE) && start;
  assign step     = (state == WRITE);

  dma_addr_step #(.ADDR_W(ADDR_W)) u_rd (
    .clk, .rst_n, .load(accept), .load_val(desc_now ? src + len_m1 : src),
    .step, .down(dir_down), .ptr(rd_ptr)
  );

  dma_addr_step #(.ADDR_W(ADDR_W)) u_wr (
    .clk, .rst_n, .load(accept), .load_val(desc_now ? dst + len_m1 : dst),
    .step, .down(dir_down), .ptr(wr_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      data_q    <= '0;
      dir_down  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        remaining <= len_c;
        dir_down  <= desc_now;
      end else if (step) begin
        remaining <= remaining - (ADDR_W+1)'(1);
      end
      if (state == READ) data_q <= mem.mem_out;
    end
  end

  // Outputs decode the registered state only, so mem_load cannot glitch.
  always_comb begin
    state_nxt       = state;
    busy            = 1'b0;
    done            = 1'b0;
    mem.mem_address = '0;
    mem.mem_in      = '0;
    mem.mem_load    = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = (len_c == '0) ? FINISH : READ;
      READ: begin
        busy            = 1'b1;
        mem.mem_address = rd_ptr;
        state_nxt       = WRITE;
      end
      WRITE: begin
        busy            = 1'b1;
        mem.mem_address = wr_ptr;
        mem.mem_in      = data_q;
        mem.mem_load    = 1'b1;
        state_nxt       = (remaining == (ADDR_W+1)'(1)) ? FINISH : READ;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram64_block_mover.sv
// Bench: block mover beside a 64-word RAM model, checked against a word-order copy model.
module tb_ram64_block_mover;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [5:0] src = '0, dst = '0;
  logic [6:0] len = '0;
  logic       busy, done;

  ram64_block_mover_if #(.WIDTH(16), .ADDR_W(6)) bus ();

  ram64_block_mover dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] ram   [64];
  logic [15:0] model [64];
  assign bus.mem_out = ram[bus.mem_address];
  always @(posedge clk) if (bus.mem_load) ram[bus.mem_address] <= bus.mem_in;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_tr[$];
  logic [6:0] act_tr[$];

  typedef struct {
    int s; int d; int l; int exp_done; int exp_busy;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Copy word by word in the order the direction rule dictates; records expected bus trace.
  task automatic model_copy(input int s, input int d, input int l);
    int n, diff, off, rs, wd;
    bit down;
    n    = (l > 64) ? 64 : l;
    diff = (d - s + 64) % 64;
    down = (diff != 0) && (diff < n);
    exp_tr.delete();
    for (int k = 0; k < n; k++) begin
      off = down ? n - 1 - k : k;
      rs  = (s + off) % 64;
      wd  = (d + off) % 64;
      exp_tr.push_back({1'b0, 6'(rs)});
      exp_tr.push_back({1'b1, 6'(wd)});
      model[wd] = model[rs];
    end
  endtask

  task automatic check_ram(input string nm);
    int bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== model[i]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic run_copy(input string nm, input int s, input int d, input int l,
                          input int exp_done, input int exp_busy, input bit inject);
    int done_at = 0, busy_n = 0, bad = 0;
    model_copy(s, d, l);
    act_tr.delete();
    @(negedge clk);
    start = 1'b1; src = 6'(s); dst = 6'(d); len = 7'(l);
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (inject && c == 3) begin
        start = 1'b1; src = 6'd50; dst = 6'd20; len = 7'd10;
      end
      if (c == 4) start = 1'b0;
      if (busy) begin
        busy_n++;
        act_tr.push_back({bus.mem_load, bus.mem_address});
      end
      if (done) begin done_at = c; break; end
    end
    chk({nm, "_done_cycle"}, done_at, exp_done);
    chk({nm, "_busy_cycles"}, busy_n, exp_busy);
    chk({nm, "_trace_len"}, act_tr.size(), exp_tr.size());
    for (int i = 0; i < act_tr.size() && i < exp_tr.size(); i++)
      if (act_tr[i] !== exp_tr[i]) bad++;
    chk({nm, "_trace_bad"}, bad, 0);
    check_ram({nm, "_ram_bad_words"});
    if (done_at != 0) begin
      // start while in FINISH must not launch a copy
      start = 1'b1; src = 6'd1; dst = 6'd2; len = 7'd3;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk({nm, "_finish_start_busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    tv[0] = '{s: 0,  d: 32, l: 4,   exp_done: 9,   exp_busy: 8};
    tv[1] = '{s: 10, d: 12, l: 4,   exp_done: 9,   exp_busy: 8};
    tv[2] = '{s: 62, d: 5,  l: 4,   exp_done: 9,   exp_busy: 8};
    tv[3] = '{s: 7,  d: 9,  l: 0,   exp_done: 1,   exp_busy: 0};
    tv[4] = '{s: 3,  d: 7,  l: 100, exp_done: 129, exp_busy: 128};
    tv[5] = '{s: 5,  d: 5,  l: 3,   exp_done: 7,   exp_busy: 6};
    tv[6] = '{s: 20, d: 18, l: 5,   exp_done: 11,  exp_busy: 10};
    tv[7] = '{s: 60, d: 2,  l: 8,   exp_done: 17,  exp_busy: 16};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_load", int'(bus.mem_load), 0);
    chk("rst_addr", int'(bus.mem_address), 0);
    chk("rst_in",   int'(bus.mem_in), 0);
    for (int i = 0; i < 64; i++) begin
      ram[i]  <= 16'(i + 100);
      model[i] = 16'(i + 100);
    end
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_copy($sformatf("vec%0d", i), tv[i].s, tv[i].d, tv[i].l,
               tv[i].exp_done, tv[i].exp_busy, 1'b0);

    // Second start mid-copy is ignored
    run_copy("midstart", 0, 40, 4, 9, 8, 1'b1);

    // Reset during the second WRITE: only the first word lands
    model[41] = model[1] ^ 16'h5a5a;
    model[40] = model[0] ^ 16'h0f0f;
    ram[41] <= model[41];
    ram[40] <= model[40];
    @(negedge clk);
    start = 1'b1; src = 6'd0; dst = 6'd40; len = 7'd4;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_load", int'(bus.mem_load), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_load", int'(bus.mem_load), 0);
    chk("rst_mid_busy", int'(busy), 0);
    model[40] = model[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int dn = 0;
      repeat (6) begin @(negedge clk); if (done) dn++; end
      chk("rst_mid_no_done", dn, 0);
    end
    check_ram("rst_mid_ram_bad_words");
    run_copy("after_rst", 0, 32, 4, 9, 8, 1'b0);

    // Randomized copies over random memory contents
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      model[i] = 16'($urandom);
      ram[i]  <= model[i];
    end
    for (int r = 0; r < 20; r++) begin
      int s, d, l, n;
      s = $urandom_range(0, 63);
      d = $urandom_range(0, 63);
      l = $urandom_range(0, 70);
      n = (l > 64) ? 64 : l;
      run_copy($sformatf("rnd%0d", r), s, d, l, 2 * n + 1, 2 * n, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
